// File: rtl/alu4_issue_ctrl.sv
// alu4_issue_ctrl: valid/ready instruction sequencer driving an external 4-bit ALU over a 4x4 register file
//   clk, reset (sync, active-high)
//   i_valid/i_ready handshake; i_ld, i_op, i_rd, i_rs1, i_rs2, i_imm describe the instruction
//   alu_a/alu_b/alu_op drive the ALU; alu_result and alu_c/n/z/v come back
//   o_done pulses after each write-back with o_wr_addr/o_wr_data; o_c/n/z/v hold the last ALU flags
//   dbg_addr/dbg_data give a combinational regfile read port
module alu4_issue_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic       i_ld,
    input  logic [2:0] i_op,
    input  logic [1:0] i_rd,
    input  logic [1:0] i_rs1,
    input  logic [1:0] i_rs2,
    input  logic [3:0] i_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    output logic       o_done,
    output logic [1:0] o_wr_addr,
    output logic [3:0] o_wr_data,
    output logic       o_c,
    output logic       o_n,
    output logic       o_z,
    output logic       o_v,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nxt;
    logic [3:0][3:0] regs;
    logic [1:0] rd;
    logic [3:0] cnt;
    logic accept, capture;
    assign i_ready = state == IDLE;
    assign accept = i_valid & i_ready;
    // the edge on which the settle counter expires is the result-capture edge
    assign capture = state == EXEC && cnt == 4'd1;
    assign dbg_data = regs[dbg_addr];
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    always_comb
        state_nxt = (accept && !i_ld) ? EXEC : capture ? IDLE : state;
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
            rd <= '0;
            cnt <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            o_done <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            {o_c, o_n, o_z, o_v} <= '0;
        end else begin
            o_done <= 1'b0;
            if (accept && i_ld) begin
                regs[i_rd] <= i_imm;
                o_done <= 1'b1;
                o_wr_addr <= i_rd;
                o_wr_data <= i_imm;
            end else if (accept) begin
                // operands are snapshotted here, so rd may alias rs1/rs2
                alu_a <= regs[i_rs1];
                alu_b <= regs[i_rs2];
                alu_op <= i_op;
                rd <= i_rd;
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (capture) begin
                    regs[rd] <= alu_result;
                    {o_c, o_n, o_z, o_v} <= {alu_c, alu_n, alu_z, alu_v};
                    o_done <= 1'b1;
                    o_wr_addr <= rd;
                    o_wr_data <= alu_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// tb_alu4_issue_ctrl: directed self-checking bench for alu4_issue_ctrl with a behavioural ALU attached
module tb_alu4_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       valid = 0, ld = 0, ready, done, c, n, z, v, ac, an, az, av;
    logic [2:0] op = 0, alu_op;
    logic [1:0] rd = 0, rs1 = 0, rs2 = 0, dbg_addr = 0, wr_addr;
    logic [3:0] imm = 0, alu_a, alu_b, ar, wr_data, dbg_data;

    logic       w_valid = 0, w_ld = 0, w_ready, w_done, w_c, w_n, w_z, w_v, w_ac, w_an, w_az, w_av;
    logic [2:0] w_op = 0, w_alu_op;
    logic [1:0] w_rd = 0, w_rs1 = 0, w_rs2 = 0, w_dbg_addr = 0, w_wr_addr;
    logic [3:0] w_imm = 0, w_alu_a, w_alu_b, w_ar, w_wr_data, w_dbg_data;

    int passed = 0, failed = 0, total = 0;

    alu4_issue_ctrl #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .i_valid(valid), .i_ready(ready), .i_ld(ld), .i_op(op),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(ar), .alu_c(ac), .alu_n(an), .alu_z(az), .alu_v(av),
        .o_done(done), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_c(c), .o_n(n), .o_z(z),
        .o_v(v), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu4_issue_ctrl #(.WAIT_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .i_valid(w_valid), .i_ready(w_ready), .i_ld(w_ld), .i_op(w_op),
        .i_rd(w_rd), .i_rs1(w_rs1), .i_rs2(w_rs2), .i_imm(w_imm), .alu_a(w_alu_a), .alu_b(w_alu_b),
        .alu_op(w_alu_op), .alu_result(w_ar), .alu_c(w_ac), .alu_n(w_an), .alu_z(w_az), .alu_v(w_av),
        .o_done(w_done), .o_wr_addr(w_wr_addr), .o_wr_data(w_wr_data), .o_c(w_c), .o_n(w_n), .o_z(w_z),
        .o_v(w_v), .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
    );

    // returns {c, n, z, v, result}
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
        logic [4:0] s;
        logic [3:0] r;
        logic cy, ov;
        cy = 1'b0;
        ov = 1'b0;
        s = '0;
        case (o)
            3'd0: r = ~a;
            3'd1: r = ~b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                cy = s[4];
                ov = (a[3] == b[3]) && (r[3] != a[3]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0];
                cy = s[4];
                ov = (a[3] != b[3]) && (r[3] != a[3]);
            end
        endcase
        return {cy, r[3], r == 4'd0, ov, r};
    endfunction

    always_comb {ac, an, az, av, ar} = alu_f(alu_a, alu_b, alu_op);
    always_comb {w_ac, w_an, w_az, w_av, w_ar} = alu_f(w_alu_a, w_alu_b, w_alu_op);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] r, input logic [3:0] d);
        valid = 1; ld = 1; rd = r; imm = d;
        step();
        valid = 0;
        chk("ld_done", done, 1);
        chk("ld_addr", wr_addr, r);
        chk("ld_data", wr_data, d);
    endtask

    task automatic aluop(input string tag, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [2:0] o, input logic [3:0] ed, input logic [3:0] ef);
        valid = 1; ld = 0; rd = d; rs1 = s1; rs2 = s2; op = o;
        step();
        valid = 0;
        chk($sformatf("%s_busy", tag), ready, 0);
        chk($sformatf("%s_nodone", tag), done, 0);
        chk($sformatf("%s_aluop", tag), alu_op, o);
        step();
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_addr", tag), wr_addr, d);
        chk($sformatf("%s_data", tag), wr_data, ed);
        chk($sformatf("%s_flags", tag), {c, n, z, v}, ef);
        chk($sformatf("%s_ready", tag), ready, 1);
        dbg_addr = d;
        #1;
        chk($sformatf("%s_dbg", tag), dbg_data, ed);
    endtask

    initial begin
        logic [3:0] exp_r [6];
        logic [3:0] exp_f [6];
        exp_r = '{4'b0101, 4'b1001, 4'b0010, 4'b1110, 4'b1100, 4'b0011};
        exp_f = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        step();
        step();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_flags", {c, n, z, v}, 0);
        chk("rst_dbg0", dbg_data, 0);
        chk("rst_w_ready", w_ready, 1);
        reset = 0;
        step();
        chk("idle_done", done, 0);

        load(2'd0, 4'd7);
        load(2'd1, 4'd1);
        aluop("add", 2'd2, 2'd0, 2'd1, 3'd6, 4'd8, 4'b0101);
        load(2'd3, 4'd3);
        aluop("sub", 2'd3, 2'd3, 2'd3, 3'd7, 4'd0, 4'b1010);

        load(2'd0, 4'b1010);
        load(2'd1, 4'b0110);
        for (int i = 0; i < 6; i++)
            aluop($sformatf("logic%0d", i), 2'd2, 2'd0, 2'd1, 3'(i), exp_r[i], exp_f[i]);

        // second instruction held on i_valid while the first is executing
        valid = 1; ld = 0; rd = 2'd3; rs1 = 2'd0; rs2 = 2'd1; op = 3'd4;
        step();
        ld = 1; rd = 2'd2; imm = 4'hf;
        chk("hold_busy", ready, 0);
        step();
        chk("hold_op_done", done, 1);
        chk("hold_op_addr", wr_addr, 3);
        chk("hold_op_data", wr_data, 4'hc);
        chk("hold_ready", ready, 1);
        step();
        valid = 0;
        chk("hold_ld_done", done, 1);
        chk("hold_ld_addr", wr_addr, 2);
        chk("hold_ld_data", wr_data, 4'hf);
        step();
        chk("hold_quiet", done, 0);
        dbg_addr = 2'd3;
        #1;
        chk("hold_dbg3", dbg_data, 4'hc);
        dbg_addr = 2'd2;
        #1;
        chk("hold_dbg2", dbg_data, 4'hf);

        for (int i = 0; i < 4; i++)
            load(2'(i), 4'(i + 1));
        step();
        chk("burst_quiet", done, 0);
        load(2'd1, 4'd5);
        chk("ld_keeps_flags", {c, n, z, v}, 4'b0100);
        chk("ld_keeps_alu_a", alu_a, 4'b1010);

        // reset on the capture edge of an in-flight op
        valid = 1; ld = 0; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd1; op = 3'd6;
        step();
        valid = 0;
        reset = 1;
        step();
        reset = 0;
        chk("rst_exec_done", done, 0);
        chk("rst_exec_ready", ready, 1);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_alu_b", alu_b, 0);
        chk("rst_exec_alu_op", alu_op, 0);
        chk("rst_exec_flags", {c, n, z, v}, 0);
        chk("rst_exec_wr", {wr_addr, wr_data}, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("rst_exec_reg%0d", i), dbg_data, 0);
        end
        step();
        chk("rst_exec_quiet", done, 0);

        // WAIT_CYCLES=4 instance
        w_valid = 1; w_ld = 1; w_rd = 2'd3; w_imm = 4'd3;
        step();
        chk("w_ld_done", w_done, 1);
        w_ld = 0; w_rs1 = 2'd3; w_rs2 = 2'd3; w_op = 3'd7;
        step();
        w_valid = 0;
        repeat (4) begin
            chk("w_busy", w_ready, 0);
            chk("w_nodone", w_done, 0);
            chk("w_hold_a", w_alu_a, 3);
            step();
        end
        chk("w_ready", w_ready, 1);
        chk("w_done", w_done, 1);
        chk("w_addr", w_wr_addr, 3);
        chk("w_data", w_wr_data, 0);
        chk("w_flags", {w_c, w_n, w_z, w_v}, 4'b1010);
        step();
        chk("w_quiet", w_done, 0);
        chk("w_keep_op", w_alu_op, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
